// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU and a
// host/debug port, CPU-first with a bounded-starvation slot for the host.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD_CPU,
    RD_HOST
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    wait_cnt;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] host_rdata_q;
  logic          perr_q;
  logic          cpu_req;
  logic          host_pri;
  logic          cpu_issue;
  logic          host_issue;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign host_pri  = (wait_cnt == 4'(STARVE_MAX));
  assign proto_err = reset_n & perr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    if (state == IDLE && mem_rd)
      state_nx = cpu_issue ? RD_CPU : RD_HOST;
  end

  // Both-strobes from the CPU counts as a write.
  always_comb begin
    cpu_issue   = 1'b0;
    host_issue  = 1'b0;
    cpu_stall   = 1'b0;
    host_gnt    = 1'b0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    cpu_rvalid  = 1'b0;
    host_rvalid = 1'b0;
    cpu_rdata   = '0;
    host_rdata  = '0;
    if (reset_n) begin
      if (state == IDLE) begin
        host_issue = host_req & (host_pri | ~cpu_req);
        cpu_issue  = cpu_req & ~host_issue;
      end
      cpu_stall = cpu_req & ~cpu_issue;
      host_gnt  = host_issue;
      unique case (1'b1)
        cpu_issue: begin
          mem_addr = cpu_addr;
          mem_wr   = cpu_wr;
          mem_rd   = ~cpu_wr;
          if (cpu_wr) mem_wdata = cpu_wdata;
        end
        host_issue: begin
          mem_addr = host_addr;
          mem_wr   = host_we;
          mem_rd   = ~host_we;
          if (host_we) mem_wdata = host_wdata;
        end
        default: ;
      endcase
      cpu_rvalid  = (state == RD_CPU);
      host_rvalid = (state == RD_HOST);
      cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
      host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || host_gnt || !host_req)
      wait_cnt <= '0;
    else if (!host_pri)
      wait_cnt <= wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      perr_q       <= 1'b0;
    end else begin
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
      if (host_rvalid) host_rdata_q <= mem_rdata;
      if (cpu_rd && cpu_wr) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios then randomized traffic, checked
// against a memory-level reference model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        proto_err;

  logic [15:0] mem [256];

  int passed = 0;
  int total  = 0;

  // reference model
  logic [15:0] ref_mem [256];
  int          owner = 0;
  int          hwait = 0;
  bit          err = 0;
  logic [15:0] lastc = '0;
  logic [15:0] lasth = '0;
  logic [7:0]  paddr = '0;
  bit          cwin, hwin;
  logic        e_stall, e_gnt, e_mrd, e_mwr, e_crv, e_hrv, e_perr;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata, e_crd, e_hrd;

  dmem_arbiter #(.AW(8), .DW(16), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [15:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    return (a == 8'h12) ? 16'hBEEF : {b, ~b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic eval();
    bit creq;
    @(negedge clk);
    creq = cpu_rd | cpu_wr;
    cwin = 0; hwin = 0;
    e_stall = 0; e_gnt = 0; e_mrd = 0; e_mwr = 0;
    e_crv = 0; e_hrv = 0; e_perr = 0;
    e_addr = '0; e_wdata = '0; e_crd = '0; e_hrd = '0;
    if (reset_n) begin
      hwin = owner == 0 && host_req && (hwait == SM || !creq);
      cwin = owner == 0 && creq && !hwin;
      e_stall = creq && !cwin;
      e_gnt   = hwin;
      if (cwin) begin
        e_addr = cpu_addr; e_mwr = cpu_wr; e_mrd = !cpu_wr;
        if (cpu_wr) e_wdata = cpu_wdata;
      end
      if (hwin) begin
        e_addr = host_addr; e_mwr = host_we; e_mrd = !host_we;
        if (host_we) e_wdata = host_wdata;
      end
      e_crv  = owner == 1;
      e_hrv  = owner == 2;
      e_crd  = (owner == 1) ? ref_mem[paddr] : lastc;
      e_hrd  = (owner == 2) ? ref_mem[paddr] : lasth;
      e_perr = err;
    end
    chk("cpu_stall", cpu_stall, e_stall);
    chk("host_gnt", host_gnt, e_gnt);
    chk("mem_rd", mem_rd, e_mrd);
    chk("mem_wr", mem_wr, e_mwr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", cpu_rvalid, e_crv);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("host_rvalid", host_rvalid, e_hrv);
    chk("host_rdata", host_rdata, e_hrd);
    chk("proto_err", proto_err, e_perr);
  endtask

  task automatic adv();
    if (!reset_n) begin
      owner = 0; hwait = 0; err = 0; lastc = '0; lasth = '0;
    end else begin
      if (owner == 1) lastc = ref_mem[paddr];
      if (owner == 2) lasth = ref_mem[paddr];
      owner = 0;
      if (e_mwr) ref_mem[e_addr] = e_wdata;
      if (e_mrd) begin
        owner = cwin ? 1 : 2;
        paddr = e_addr;
      end
      if (hwin || !host_req) hwait = 0;
      else if (hwait < SM)   hwait = hwait + 1;
      if (cpu_rd && cpu_wr) err = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    // reset
    eval(); adv();
    eval(); adv();
    reset_n = 1'b1;
    eval(); adv();

    // CPU read with 1-cycle return
    cpu_rd = 1; cpu_addr = 8'h12;
    eval(); chk("t1_mem_rd", mem_rd, 1); chk("t1_stall", cpu_stall, 0);
    adv(); cpu_rd = 0;
    eval(); chk("t1_rvalid", cpu_rvalid, 1);
    chk("t1_rdata", cpu_rdata, 16'hBEEF);
    adv(); cpu_rd = 1; cpu_addr = 8'h13;
    eval(); chk("t1_reissue", cpu_stall, 0);
    adv(); cpu_rd = 0;
    eval(); adv();

    // host write while CPU idle
    host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 16'h1234;
    eval(); chk("t2_gnt", host_gnt, 1); chk("t2_mem_wr", mem_wr, 1);
    chk("t2_addr", mem_addr, 8'h40); chk("t2_wdata", mem_wdata, 16'h1234);
    adv(); host_req = 0;

    // CPU write burst starving a host write
    host_req = 1; host_we = 1; host_addr = 8'h41; host_wdata = 16'h5555;
    cpu_wr = 1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 8'(8'h60 + i); cpu_wdata = 16'(i);
      eval(); chk("t3_cpu_issue", cpu_stall, 0); chk("t3_host_wait", host_gnt, 0);
      adv();
    end
    cpu_addr = 8'h64; cpu_wdata = 16'h0004;
    eval(); chk("t3_host_win", host_gnt, 1); chk("t3_stall", cpu_stall, 1);
    adv(); host_req = 0;
    eval(); chk("t3_resume", cpu_stall, 0); chk("t3_resume_wr", mem_wr, 1);
    adv(); cpu_wr = 0;

    // CPU read and host read together
    cpu_rd = 1; cpu_addr = 8'h40;
    host_req = 1; host_we = 0; host_addr = 8'h12;
    eval(); chk("t4_cpu_rd", mem_rd, 1); chk("t4_gnt0", host_gnt, 0);
    adv(); cpu_rd = 0;
    eval(); chk("t4_bubble", host_gnt, 0); chk("t4_crdata", cpu_rdata, 16'h1234);
    adv();
    eval(); chk("t4_gnt", host_gnt, 1); chk("t4_haddr", mem_addr, 8'h12);
    adv(); host_req = 0;
    eval(); chk("t4_hrv", host_rvalid, 1); chk("t4_hrdata", host_rdata, 16'hBEEF);
    adv();

    // both CPU strobes: write plus sticky error
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 8'h50; cpu_wdata = 16'hA5A5;
    eval(); chk("t5_wr", mem_wr, 1); chk("t5_rd", mem_rd, 0);
    chk("t5_perr0", proto_err, 0);
    adv(); cpu_rd = 0; cpu_wr = 0;
    for (int i = 0; i < 3; i++) begin
      eval(); chk("t5_perr", proto_err, 1); adv();
    end
    reset_n = 0;
    eval(); adv();
    reset_n = 1;
    eval(); chk("t5_perr_clr", proto_err, 0); adv();

    // reset during a read
    cpu_rd = 1; cpu_addr = 8'h12;
    eval(); chk("t6_issue", mem_rd, 1);
    adv(); cpu_rd = 0; reset_n = 0;
    eval(); chk("t6_rv1", cpu_rvalid, 0); chk("t6_rd1", cpu_rdata, 0);
    adv(); reset_n = 1;
    eval(); chk("t6_rv2", cpu_rvalid, 0); chk("t6_rd2", cpu_rdata, 0);
    adv(); cpu_rd = 1; cpu_addr = 8'h50;
    eval(); adv(); cpu_rd = 0;
    eval(); chk("t6_resume", cpu_rdata, 16'hA5A5); adv();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(79) != 0);
      if (!(e_stall && (cpu_rd || cpu_wr))) begin
        int r;
        r = $urandom_range(63);
        cpu_rd = 0; cpu_wr = 0;
        if (r == 0) begin cpu_rd = 1; cpu_wr = 1; end
        else if (r < 24) cpu_rd = 1;
        else if (r < 44) cpu_wr = 1;
        cpu_addr  = 8'($urandom_range(15));
        cpu_wdata = 16'($urandom);
      end
      if (host_req && !e_gnt) begin
        if ($urandom_range(15) == 0) host_req = 0;
      end else begin
        host_req   = ($urandom_range(2) == 0);
        host_we    = $urandom_range(1) == 1;
        host_addr  = 8'($urandom_range(15));
        host_wdata = 16'($urandom);
      end
      eval();
      adv();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
